// File: rtl/motor_driver.sv
// motor_driver: two-wheel H-bridge PWM driver with soft start/stop and a dead time before reversal.
// Optional duty ramping is enabled by defining MOTOR_SOFT_START_EN; otherwise duty steps 0 <-> DUTY_MAX.
module motor_driver #(
  parameter int PWM_BITS    = 8,
  parameter int DUTY_MAX    = 200,
  parameter int RAMP_STEP   = 8,
  parameter int RAMP_DIV    = 1000,
  parameter int DEAD_CYCLES = 50
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       avancar,
  input  logic       girar,
  output logic       pwm_esq,
  output logic       pwm_dir,
  output logic       sentido_esq,
  output logic       sentido_dir,
  output logic       em_movimento,
  output logic [2:0] estado
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    RUN       = 3'd2,
    RAMP_DOWN = 3'd3,
    DEAD      = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    CMD_STOP = 2'd0,
    CMD_FWD  = 2'd1,
    CMD_ROT  = 2'd2
  } cmd_t;

  localparam logic [PWM_BITS-1:0] DUTY_TOP = PWM_BITS'(DUTY_MAX);
  localparam int DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

  state_t              state;
  cmd_t                target;
  cmd_t                modo;
  logic [PWM_BITS-1:0] duty;
  logic [PWM_BITS-1:0] duty_up;
  logic [PWM_BITS-1:0] duty_dn;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [DEAD_W-1:0]   dead_cnt;
  logic [31:0]         duty_sum;
  logic                tick;
  logic                dead_end;

`ifdef MOTOR_SOFT_START_EN
  localparam int STEP   = RAMP_STEP;
  localparam int TICK_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  logic [TICK_W-1:0] tick_cnt;

  assign tick = (tick_cnt == TICK_W'(RAMP_DIV - 1));

  // Runs only while ramping and keeps counting across RAMP_UP <-> RAMP_DOWN turnarounds.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (state == RAMP_UP || state == RAMP_DOWN) begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
    end else begin
      tick_cnt <= '0;
    end
  end
`else
  // A full-scale step on every cycle makes each ramp a single jump.
  localparam int STEP = DUTY_MAX;

  assign tick = 1'b1;
`endif

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    target = CMD_STOP;
    case ({avancar, girar})
      2'b10:   target = CMD_FWD;
      2'b01:   target = CMD_ROT;
      default: target = CMD_STOP;
    endcase
  end

  always_comb begin
    duty_sum = 32'(duty) + 32'(STEP);
    duty_up  = (duty_sum >= 32'(DUTY_MAX)) ? DUTY_TOP : duty_sum[PWM_BITS-1:0];
    duty_dn  = (32'(duty) > 32'(STEP)) ? duty - PWM_BITS'(STEP) : '0;
  end

  assign dead_end     = (dead_cnt == DEAD_W'(DEAD_CYCLES - 1));
  assign em_movimento = (duty != '0);
  assign estado       = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      duty        <= '0;
      modo        <= CMD_FWD;
      dead_cnt    <= '0;
      sentido_esq <= 1'b1;
      sentido_dir <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (target != CMD_STOP) begin
            modo        <= target;
            sentido_esq <= 1'b1;
            sentido_dir <= (target == CMD_FWD);
            state       <= RAMP_UP;
          end
        end
        RAMP_UP: begin
          if (target != modo)      state <= RAMP_DOWN;
          else if (duty == DUTY_TOP) state <= RUN;
          else if (tick)           duty  <= duty_up;
        end
        RUN: begin
          if (target != modo) state <= RAMP_DOWN;
        end
        RAMP_DOWN: begin
          if (target == modo) begin
            state <= RAMP_UP;
          end else if (duty == '0) begin
            state    <= DEAD;
            dead_cnt <= '0;
          end else if (tick) begin
            duty <= duty_dn;
          end
        end
        DEAD: begin
          // Direction may only change here, with duty already held at zero.
          if (dead_end) begin
            if (target == CMD_STOP) begin
              state <= IDLE;
            end else begin
              modo        <= target;
              sentido_esq <= 1'b1;
              sentido_dir <= (target == CMD_FWD);
              state       <= RAMP_UP;
            end
          end else begin
            dead_cnt <= dead_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pwm_cnt <= '0;
      pwm_esq <= 1'b0;
      pwm_dir <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      pwm_esq <= (pwm_cnt < duty);
      pwm_dir <= (pwm_cnt < duty);
    end
  end

endmodule

// File: tb/tb_motor_driver.sv
// Directed bench for motor_driver (PWM_BITS=4, DUTY_MAX=12, RAMP_STEP=5, RAMP_DIV=2, DEAD_CYCLES=3).
// Expected traces follow MOTOR_SOFT_START_EN as seen by this compilation.
module tb_motor_driver;

  logic       clock;
  logic       reset;
  logic       avancar;
  logic       girar;
  logic       pwm_esq;
  logic       pwm_dir;
  logic       sentido_esq;
  logic       sentido_dir;
  logic       em_movimento;
  logic [2:0] estado;

  int vectors;
  int miscompares;

  motor_driver #(
    .PWM_BITS   (4),
    .DUTY_MAX   (12),
    .RAMP_STEP  (5),
    .RAMP_DIV   (2),
    .DEAD_CYCLES(3)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .avancar     (avancar),
    .girar       (girar),
    .pwm_esq     (pwm_esq),
    .pwm_dir     (pwm_dir),
    .sentido_esq (sentido_esq),
    .sentido_dir (sentido_dir),
    .em_movimento(em_movimento),
    .estado      (estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic wait_for(input logic [2:0] s, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (estado === s) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; avancar = 1'b1; girar = 1'b0;
    repeat (3) step();
    vectors += 7;
    if (estado !== 3'd0)       begin miscompares++; $display("FAIL reset estado: got %0d expected 0", estado); end
    if (dut.duty !== 4'd0)     begin miscompares++; $display("FAIL reset duty: got %0d expected 0", dut.duty); end
    if (pwm_esq !== 1'b0)      begin miscompares++; $display("FAIL reset pwm_esq: got %b expected 0", pwm_esq); end
    if (pwm_dir !== 1'b0)      begin miscompares++; $display("FAIL reset pwm_dir: got %b expected 0", pwm_dir); end
    if (sentido_esq !== 1'b1)  begin miscompares++; $display("FAIL reset sentido_esq: got %b expected 1", sentido_esq); end
    if (sentido_dir !== 1'b1)  begin miscompares++; $display("FAIL reset sentido_dir: got %b expected 1", sentido_dir); end
    if (em_movimento !== 1'b0) begin miscompares++; $display("FAIL reset em_movimento: got %b expected 0", em_movimento); end
    reset = 1'b0;
  endtask

  task automatic test_ramp_up;
`ifdef MOTOR_SOFT_START_EN
    int exp_st   [8] = '{1, 1, 1, 1, 1, 1, 1, 2};
    int exp_duty [8] = '{0, 0, 5, 5, 10, 10, 12, 12};
`else
    int exp_st   [3] = '{1, 1, 2};
    int exp_duty [3] = '{0, 12, 12};
`endif
    int hi_esq = 0;
    int hi_dir = 0;
    for (int i = 0; i < $size(exp_st); i++) begin
      step();
      vectors += 3;
      if (estado !== 3'(exp_st[i])) begin
        miscompares++; $display("FAIL ramp_up estado[%0d]: got %0d expected %0d", i, estado, exp_st[i]);
      end
      if (dut.duty !== 4'(exp_duty[i])) begin
        miscompares++; $display("FAIL ramp_up duty[%0d]: got %0d expected %0d", i, dut.duty, exp_duty[i]);
      end
      if (em_movimento !== (exp_duty[i] != 0)) begin
        miscompares++; $display("FAIL ramp_up em_movimento[%0d]: got %b expected %b", i, em_movimento, exp_duty[i] != 0);
      end
    end
    for (int i = 0; i < 16; i++) begin
      step();
      if (pwm_esq === 1'b1) hi_esq++;
      if (pwm_dir === 1'b1) hi_dir++;
    end
    vectors += 4;
    if (hi_esq != 12) begin miscompares++; $display("FAIL run pwm_esq high count: got %0d expected 12", hi_esq); end
    if (hi_dir != 12) begin miscompares++; $display("FAIL run pwm_dir high count: got %0d expected 12", hi_dir); end
    if (sentido_esq !== 1'b1) begin miscompares++; $display("FAIL run sentido_esq: got %b expected 1", sentido_esq); end
    if (sentido_dir !== 1'b1) begin miscompares++; $display("FAIL run sentido_dir: got %b expected 1", sentido_dir); end
  endtask

  task automatic test_reversal;
`ifdef MOTOR_SOFT_START_EN
    int exp_st   [11] = '{3, 3, 3, 3, 3, 3, 3, 4, 4, 4, 1};
    int exp_duty [11] = '{12, 12, 7, 7, 2, 2, 0, 0, 0, 0, 0};
    int exp_sdir [11] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
`else
    int exp_st   [6] = '{3, 3, 4, 4, 4, 1};
    int exp_duty [6] = '{12, 0, 0, 0, 0, 0};
    int exp_sdir [6] = '{1, 1, 1, 1, 1, 0};
`endif
    bit ok;
    avancar = 1'b0; girar = 1'b1;
    for (int i = 0; i < $size(exp_st); i++) begin
      step();
      vectors += 4;
      if (estado !== 3'(exp_st[i])) begin
        miscompares++; $display("FAIL reversal estado[%0d]: got %0d expected %0d", i, estado, exp_st[i]);
      end
      if (dut.duty !== 4'(exp_duty[i])) begin
        miscompares++; $display("FAIL reversal duty[%0d]: got %0d expected %0d", i, dut.duty, exp_duty[i]);
      end
      if (sentido_dir !== 1'(exp_sdir[i])) begin
        miscompares++; $display("FAIL reversal sentido_dir[%0d]: got %b expected %0d", i, sentido_dir, exp_sdir[i]);
      end
      if (sentido_esq !== 1'b1) begin
        miscompares++; $display("FAIL reversal sentido_esq[%0d]: got %b expected 1", i, sentido_esq);
      end
    end
    wait_for(3'd2, ok);
    vectors += 2;
    if (!ok) begin miscompares++; $display("FAIL reversal reach_run: estado %0d, wanted 2 within 60 cycles", estado); end
    if (sentido_dir !== 1'b0) begin miscompares++; $display("FAIL reversal run sentido_dir: got %b expected 0", sentido_dir); end
  endtask

  task automatic test_stop;
`ifdef MOTOR_SOFT_START_EN
    int exp_st [11] = '{3, 3, 3, 3, 3, 3, 3, 4, 4, 4, 0};
`else
    int exp_st [6] = '{3, 3, 4, 4, 4, 0};
`endif
    int hi = 0;
    avancar = 1'b1; girar = 1'b1;
    for (int i = 0; i < $size(exp_st); i++) begin
      step();
      vectors++;
      if (estado !== 3'(exp_st[i])) begin
        miscompares++; $display("FAIL stop estado[%0d]: got %0d expected %0d", i, estado, exp_st[i]);
      end
    end
    for (int i = 0; i < 16; i++) begin
      step();
      if (pwm_esq !== 1'b0 || pwm_dir !== 1'b0) hi++;
    end
    vectors += 3;
    if (hi != 0) begin miscompares++; $display("FAIL stop pwm not low: got %0d high cycles expected 0", hi); end
    if (em_movimento !== 1'b0) begin miscompares++; $display("FAIL stop em_movimento: got %b expected 0", em_movimento); end
    if (estado !== 3'd0) begin miscompares++; $display("FAIL stop idle hold: got %0d expected 0", estado); end
  endtask

  task automatic test_ramp_return;
`ifdef MOTOR_SOFT_START_EN
    int down_edges   = 3;
    int exp_down     = 7;
    int exp_st   [3] = '{1, 1, 2};
    int exp_duty [3] = '{7, 12, 12};
`else
    int down_edges   = 1;
    int exp_down     = 12;
    int exp_st   [2] = '{1, 2};
    int exp_duty [2] = '{12, 12};
`endif
    bit ok;
    avancar = 1'b1; girar = 1'b0;
    wait_for(3'd2, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL return reach_run: estado %0d, wanted 2 within 60 cycles", estado); end
    avancar = 1'b0;
    repeat (down_edges) step();
    vectors += 2;
    if (estado !== 3'd3) begin miscompares++; $display("FAIL return ramp_down estado: got %0d expected 3", estado); end
    if (dut.duty !== 4'(exp_down)) begin miscompares++; $display("FAIL return ramp_down duty: got %0d expected %0d", dut.duty, exp_down); end
    avancar = 1'b1;
    for (int i = 0; i < $size(exp_st); i++) begin
      step();
      vectors += 3;
      if (estado !== 3'(exp_st[i])) begin
        miscompares++; $display("FAIL return estado[%0d]: got %0d expected %0d", i, estado, exp_st[i]);
      end
      if (dut.duty !== 4'(exp_duty[i])) begin
        miscompares++; $display("FAIL return duty[%0d]: got %0d expected %0d", i, dut.duty, exp_duty[i]);
      end
      if (sentido_esq !== 1'b1 || sentido_dir !== 1'b1) begin
        miscompares++; $display("FAIL return sentido[%0d]: got %b%b expected 11", i, sentido_esq, sentido_dir);
      end
    end
  endtask

  task automatic test_dead_toggle;
    bit ok;
    avancar = 1'b0; girar = 1'b0;
    wait_for(3'd4, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL dead reach_dead: estado %0d, wanted 4 within 60 cycles", estado); end
    girar = 1'b1;
    step();
    vectors++;
    if (estado !== 3'd4) begin miscompares++; $display("FAIL dead hold1 estado: got %0d expected 4", estado); end
    girar = 1'b0;
    step();
    vectors++;
    if (estado !== 3'd4) begin miscompares++; $display("FAIL dead hold2 estado: got %0d expected 4", estado); end
    girar = 1'b1;
    step();
    vectors += 3;
    if (estado !== 3'd1)      begin miscompares++; $display("FAIL dead exit estado: got %0d expected 1", estado); end
    if (sentido_dir !== 1'b0) begin miscompares++; $display("FAIL dead exit sentido_dir: got %b expected 0", sentido_dir); end
    if (sentido_esq !== 1'b1) begin miscompares++; $display("FAIL dead exit sentido_esq: got %b expected 1", sentido_esq); end
    step();
    vectors++;
    if (estado !== 3'd1) begin miscompares++; $display("FAIL dead after_exit estado: got %0d expected 1", estado); end
  endtask

  task automatic test_async_reset;
`ifdef MOTOR_SOFT_START_EN
    int run_edges = 4;
    int exp_st    = 1;
`else
    int run_edges = 3;
    int exp_st    = 2;
`endif
    reset = 1'b1; avancar = 1'b1; girar = 1'b0;
    #1;
    vectors += 2;
    if (estado !== 3'd0)      begin miscompares++; $display("FAIL async1 estado: got %0d expected 0", estado); end
    if (sentido_dir !== 1'b1) begin miscompares++; $display("FAIL async1 sentido_dir: got %b expected 1", sentido_dir); end
    repeat (2) step();
    reset = 1'b0;
    repeat (run_edges) step();
    vectors += 3;
    if (estado !== 3'(exp_st)) begin miscompares++; $display("FAIL async2 pre estado: got %0d expected %0d", estado, exp_st); end
    if (pwm_esq !== 1'b1) begin miscompares++; $display("FAIL async2 pre pwm_esq: got %b expected 1", pwm_esq); end
    if (pwm_dir !== 1'b1) begin miscompares++; $display("FAIL async2 pre pwm_dir: got %b expected 1", pwm_dir); end
    #2 reset = 1'b1;
    #1;
    vectors += 4;
    if (pwm_esq !== 1'b0)      begin miscompares++; $display("FAIL async2 pwm_esq: got %b expected 0", pwm_esq); end
    if (pwm_dir !== 1'b0)      begin miscompares++; $display("FAIL async2 pwm_dir: got %b expected 0", pwm_dir); end
    if (estado !== 3'd0)       begin miscompares++; $display("FAIL async2 estado: got %0d expected 0", estado); end
    if (em_movimento !== 1'b0) begin miscompares++; $display("FAIL async2 em_movimento: got %b expected 0", em_movimento); end
    step();
    reset = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    avancar     = 1'b1;
    girar       = 1'b0;
    test_reset();
    test_ramp_up();
    test_reversal();
    test_stop();
    test_ramp_return();
    test_dead_toggle();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
